// File: rtl/fsub_pipe.sv
// Three-stage IEEE-754 single-precision add/subtract pipeline. Truncating, no subnormals.
// Define FSUB_OVF_SAT_EN to saturate an overflowing exponent to signed infinity.
module fsub_pipe (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        op,
  input  logic [31:0] x1,
  input  logic [31:0] x2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y
);

  logic advance;

  // S1 combinational: swap and align
  logic        sign_b;
  logic [7:0]  exp_a, exp_b;
  logic [22:0] man_a, man_b;
  logic        swap;
  logic        big_sign, sml_sign;
  logic [7:0]  big_exp, sml_exp, diff;
  logic [22:0] big_man, sml_man;
  logic [24:0] big_sig, sml_sig, sml_aligned;

  // Stage registers
  logic        s1_valid, s1_sign, s1_sub;
  logic [7:0]  s1_exp;
  logic [24:0] s1_big, s1_sml;
  logic        s2_valid, s2_sign;
  logic [7:0]  s2_exp;
  logic [25:0] s2_sum;

  // S2 / S3 combinational
  logic [25:0] sum_d;
  logic [4:0]  lz;
  logic [9:0]  exp_n;
  logic [22:0] mant_n;
  logic [31:0] y_d;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  always_comb begin
    sign_b  = x2[31] ^ op;
    exp_a   = x1[30:23];
    exp_b   = x2[30:23];
    // A zero exponent means zero, so its mantissa must not win the magnitude compare.
    man_a   = (exp_a == 8'd0) ? 23'd0 : x1[22:0];
    man_b   = (exp_b == 8'd0) ? 23'd0 : x2[22:0];
    swap    = {exp_b, man_b} > {exp_a, man_a};
    big_sign = swap ? sign_b : x1[31];
    sml_sign = swap ? x1[31] : sign_b;
    big_exp  = swap ? exp_b : exp_a;
    sml_exp  = swap ? exp_a : exp_b;
    big_man  = swap ? man_b : man_a;
    sml_man  = swap ? man_a : man_b;
    diff     = big_exp - sml_exp;
    big_sig  = {|big_exp, big_man, 1'b0};
    sml_sig  = {|sml_exp, sml_man, 1'b0};
    sml_aligned = (diff >= 8'd25) ? 25'd0 : (sml_sig >> diff);
  end

  always_comb begin
    if (s1_sub) sum_d = {1'b0, s1_big} - {1'b0, s1_sml};
    else        sum_d = {1'b0, s1_big} + {1'b0, s1_sml};
  end

  // S3: leading-one detect, normalise so the leading one lands on bit 25.
  always_comb begin
    lz = 5'd0;
    for (int i = 0; i < 26; i++) begin
      if (s2_sum[i]) lz = 5'(25 - i);
    end
    exp_n  = {2'b00, s2_exp} + 10'd1 - {5'd0, lz};
    mant_n = 23'((s2_sum << lz) >> 2);
    if (s2_sum == 26'd0 || exp_n[9] || exp_n[8:0] == 9'd0) begin
      y_d = 32'd0;
    end
`ifdef FSUB_OVF_SAT_EN
    else if (exp_n >= 10'd255) begin
      y_d = {s2_sign, 8'hff, 23'd0};
    end
`endif
    else begin
      y_d = {s2_sign, exp_n[7:0], mant_n};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_sub    <= 1'b0;
      s1_exp    <= 8'd0;
      s1_big    <= 25'd0;
      s1_sml    <= 25'd0;
      s2_valid  <= 1'b0;
      s2_sign   <= 1'b0;
      s2_exp    <= 8'd0;
      s2_sum    <= 26'd0;
      out_valid <= 1'b0;
      y         <= 32'd0;
    end else if (advance) begin
      s1_valid  <= in_valid;
      s1_sign   <= big_sign;
      s1_sub    <= big_sign ^ sml_sign;
      s1_exp    <= big_exp;
      s1_big    <= big_sig;
      s1_sml    <= sml_aligned;
      s2_valid  <= s1_valid;
      s2_sign   <= s1_sign;
      s2_exp    <= s1_exp;
      s2_sum    <= sum_d;
      out_valid <= s2_valid;
      if (s2_valid) y <= y_d;
    end
  end

endmodule

// File: tb/tb_fsub_pipe.sv
// Self-checking bench for fsub_pipe: directed vectors plus randomized traffic with
// random back-pressure, scored against an integer-arithmetic reference model.
module tb_fsub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        op;
  logic [31:0] x1, x2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] y_hold;

`ifdef FSUB_OVF_SAT_EN
  localparam logic [31:0] OvfWant = 32'h7f800000;
`else
  localparam logic [31:0] OvfWant = 32'h7fffffff;
`endif

  fsub_pipe dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .x1        (x1),
    .x2        (x2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] want);
    n_checks++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, want);
    end
  endtask

  // Reference: significands as integers with one guard bit, aligned smaller operand
  // truncated, result renormalised by repeated doubling/halving.
  function automatic logic [31:0] ref_add(input logic o, input logic [31:0] a,
                                          input logic [31:0] b);
    logic   sa, sb, sbig, ssml;
    int     ea, eb, ebig, esml, d, e;
    longint ma, mb, mbig, msml, r;
    sa = a[31];
    sb = b[31] ^ o;
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    ma = (ea == 0) ? 0 : longint'(a[22:0]) + 64'd8388608;
    mb = (eb == 0) ? 0 : longint'(b[22:0]) + 64'd8388608;
    if (ea > eb || (ea == eb && ma >= mb)) begin
      sbig = sa; ssml = sb; ebig = ea; esml = eb; mbig = ma; msml = mb;
    end else begin
      sbig = sb; ssml = sa; ebig = eb; esml = ea; mbig = mb; msml = ma;
    end
    d = ebig - esml;
    msml = (d >= 25) ? 0 : (msml * 2) >> d;
    mbig = mbig * 2;
    r = (sbig == ssml) ? mbig + msml : mbig - msml;
    e = ebig;
    if (r == 0) return 32'd0;
    while (r >= 64'd33554432) begin r = r >> 1; e++; end
    while (r < 64'd16777216) begin r = r << 1; e--; end
    if (e <= 0) return 32'd0;
`ifdef FSUB_OVF_SAT_EN
    if (e >= 255) return {sbig, 8'hff, 23'd0};
`endif
    return {sbig, 8'(e), 23'(r >> 1)};
  endfunction

  function automatic logic [31:0] rand_fp();
    logic [7:0] e;
    e = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Scoreboard: sampled on the falling edge, handshakes complete on the next rising edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check_eq("spurious_out", {31'd0, out_valid}, 32'd0);
        else check_eq("scoreboard", y, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(ref_add(op, x1, x2));
    end
  end

  task automatic send_one(input string tag, input logic o, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want);
    int lat;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; x1 = a; x2 = b; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check_eq({tag, "_lat"}, 32'(lat), 32'd3);
    check_eq(tag, y, want);
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check_eq(tag, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; op = 1'b0; x1 = '0; x2 = '0; out_ready = 1'b1;
    #12;
    check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check_eq("rst_y", y, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    send_one("sub_3m1", 1'b1, 32'h40400000, 32'h3f800000, 32'h40000000);
    send_one("cancel_sub", 1'b1, 32'h3f800000, 32'h3f800000, 32'h00000000);
    send_one("cancel_add", 1'b0, 32'hbf800000, 32'h3f800000, 32'h00000000);
    send_one("trunc_tiny", 1'b0, 32'h3f800000, 32'h33800000, 32'h3f800000);
    send_one("sub_neg", 1'b1, 32'h3f800000, 32'hbf000000, 32'h3fc00000);
    send_one("neg_result", 1'b1, 32'h3f800000, 32'h40400000, 32'hc0000000);
    send_one("denorm_zero", 1'b0, 32'h00400000, 32'h3f800000, 32'h3f800000);
    send_one("underflow", 1'b1, 32'h00c00000, 32'h00800000, 32'h00000000);
    send_one("overflow", 1'b0, 32'h7f7fffff, 32'h7f7fffff, OvfWant);

    // Four back-to-back accepts, then consumer stalls for two cycles.
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      in_valid  = (k < 4);
      x1        = rand_fp();
      x2        = rand_fp();
      op        = 1'($urandom);
      out_ready = !(k == 4 || k == 5);
      @(negedge clk);
      if (k == 4) begin
        check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
        check_eq("bp_out_valid", {31'd0, out_valid}, 32'd1);
        y_hold = y;
      end
      if (k == 5) check_eq("bp_y_stable", y, y_hold);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain("bp_drain");

    // Reset while two operations are in flight.
    @(posedge clk); #1;
    in_valid = 1'b1; op = 1'b0; x1 = 32'h3f800000; x2 = 32'h3f800000;
    @(posedge clk); #1;
    x1 = 32'h40000000; x2 = 32'h40000000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    check_eq("rst_pre_valid", {31'd0, out_valid}, 32'd1);
    rst = 1'b1;
    #1;
    check_eq("rst_async_valid", {31'd0, out_valid}, 32'd0);
    check_eq("rst_async_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    send_one("post_rst", 1'b0, 32'h40400000, 32'h3f800000, 32'h40800000);

    // Randomized traffic with random stalls.
    for (int k = 0; k < 400; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      op        = 1'($urandom);
      x1        = rand_fp();
      if (x1[30:23] > 8'd1 && $urandom_range(0, 2) == 0)
        x2 = {1'($urandom), x1[30:23] - 8'($urandom_range(0, 1)),
              x1[22:0] ^ 23'($urandom_range(0, 255))};
      else
        x2 = rand_fp();
      out_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    drain("rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsub_pipe.md
FSUB_PIPE -- requirements
Module: fsub_pipe

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all registers update on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port in_valid, input, 1 bit: operand pair and op are valid this cycle.
REQ-004 SHALL have port in_ready, output, 1 bit: block accepts an operand pair this cycle.
REQ-005 SHALL have port op, input, 1 bit: 0 = x1 + x2, 1 = x1 - x2.
REQ-006 SHALL have port x1, input, 32 bits: IEEE-754 single operand {sign, exp[7:0], man[22:0]}.
REQ-007 SHALL have port x2, input, 32 bits: IEEE-754 single operand, same format.
REQ-008 SHALL have port out_valid, output, 1 bit: y holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer takes y this cycle.
REQ-010 SHALL have port y, output, 32 bits: IEEE-754 single result.

Function
REQ-011 SHALL accept a transfer when in_valid and in_ready are both 1, and deliver a result when out_valid and out_ready are both 1.
REQ-012 SHALL form effective x2 sign as x2[31] ^ op before any arithmetic.
REQ-013 SHALL use three registered stages: S1 swap/align, S2 add/subtract, S3 normalize into the y register.
REQ-014 S1 SHALL pick the larger-magnitude operand by comparing {exp, man} (31 bits) and take the exponent difference d.
REQ-015 S1 SHALL right-shift the smaller significand {1, man, guard} by d; any d >= 25 SHALL give zero.
REQ-016 S2 SHALL add the significands when the effective signs match, and subtract smaller from larger otherwise, in a 26-bit datapath.
REQ-017 S3 SHALL use a leading-one detector over 26 bits to normalize; carry-out SHALL increment the exponent, and a left shift of k SHALL subtract k.
REQ-018 Rounding SHALL be truncation (round toward zero); dropped bits SHALL be discarded.
REQ-019 Result sign SHALL be the sign of the larger-magnitude operand after the op adjustment.
REQ-020 An exact-zero difference SHALL give +0 (0x00000000).
REQ-021 Any input with exp == 0 SHALL be treated as zero of that sign; NaN and infinity inputs are not supported, and their output is unspecified.
REQ-022 An exponent underflow (biased exponent <= 0 after normalize) SHALL flush y to +0.
REQ-023 Latency SHALL be exactly 3 cycles from the accepting edge to out_valid = 1 when out_ready stays 1.
REQ-024 Throughput SHALL be one result per cycle when out_ready stays 1.
REQ-025 Each stage SHALL carry a valid bit, and the whole pipeline SHALL advance only when !out_valid || out_ready.
REQ-026 in_ready SHALL equal !out_valid || out_ready, i.e. a global stall.
REQ-027 While stalled, all stage registers and y SHALL hold; no result SHALL be lost or duplicated, and results SHALL leave in order.
REQ-028 When the pipeline advances and the S3 input stage is empty, out_valid SHALL go 0 after the current result is taken.

Reset
REQ-029 On rst = 1, all stage valid bits and out_valid SHALL clear to 0 immediately, without waiting for clk.
REQ-030 On rst = 1, y and all datapath registers SHALL clear to 0.
REQ-031 During reset, in_ready SHALL read 1 (out_valid = 0).
REQ-032 Operations in flight at reset SHALL be discarded.
REQ-033 The first accept SHALL occur on the first rising clk edge after rst falls.

Configuration
REQ-034 With macro FSUB_OVF_SAT_EN defined, a normalized exponent >= 255 SHALL produce signed infinity: {sign, 8'hFF, 23'h0}.
REQ-035 Without FSUB_OVF_SAT_EN, the exponent SHALL be truncated to 8 bits with the mantissa kept, i.e. no overflow detection, and no extra logic SHALL be built.

Verification
REQ-036 Subtraction: x1 = 0x40400000 (3.0), x2 = 0x3F800000 (1.0), op = 1 -> y = 0x40000000 with out_valid 3 cycles after accept.
REQ-037 Exact cancellation: x1 = x2 = 0x3F800000, op = 1 -> y = 0x00000000; then x1 = 0xBF800000, x2 = 0x3F800000, op = 0 -> y = 0x00000000.
REQ-038 Truncation: x1 = 0x3F800000, x2 = 0x33800000 (2^-24), op = 0 -> y = 0x3F800000; then x1 = 0x3F800000, x2 = 0xBF000000 (-0.5), op = 1 -> y = 0x3FC00000.
REQ-039 Back-pressure: four back-to-back accepts, out_ready = 0 for cycles 4-5 -> in_ready = 0 while out_valid = 1, y stable, and all four results appear in order with none dropped.
REQ-040 Overflow: x1 = x2 = 0x7F7FFFFF, op = 0 -> y = 0x7F800000 with FSUB_OVF_SAT_EN defined.
REQ-041 Reset mid-flight: rst pulsed 1 cycle after two accepts -> out_valid = 0 at once, no stale result appears afterwards, and the next accepted pair's result appears 3 cycles after its accept.
